// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encodings
// and the helper that sizes the bit counter.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..w-1, never less than one.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder: the bit-slice datapath of the serial adder/subtractor.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c0,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ c0;
    assign c = (a & b) | (a & c0) | (b & c0);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first,
// registered carry, WIDTH+1 cycles from accepted start to the done pulse.
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   s_r;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               cout_r;
    logic               ovf_r;
    logic               fa_s;
    logic               fa_c;
    logic               accept;
    logic               last_bit;

    full_adder u_full_adder (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c0 (carry),
        .s  (fa_s),
        .c  (fa_c)
    );

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_RUN;
            ST_RUN:  if (last_bit) state_n = ST_DONE;
            ST_DONE: state_n = accept ? ST_RUN : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from before the edge, in any block order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Control-visible registers: these carry defined reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            s_r   <= '0;
            cnt   <= '0;
            carry <= sub;
        end else if (state == ST_RUN) begin
            s_r   <= {fa_s, s_r[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
            carry <= fa_c;
            if (last_bit) begin
                cout_r <= fa_c;
                ovf_r  <= carry ^ fa_c;
            end
        end
    end

    // NOTE: the operand shift registers are deliberately not reset; they are
    // always reloaded on an accepted start before any bit is consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr <= a;
            b_sr <= sub ? ~b : b;
        end else if (state == ST_RUN) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub (WIDTH=8): timing, boundary
// vectors, start-in-RUN, back-to-back, mid-run reset and a coarse operand sweep.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // One clock: inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation with start for one edge; afterwards we are in cycle 1.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub);
        a     = va;
        b     = vb;
        sub   = vsub;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Steps until done; n = cycle index of done counted from the launch, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            if (done === 1'b1) begin
                n = c;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        step();
        step();
        checks++;
        if ({busy, done, s, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: busy=%b done=%b s=%h cout=%b ovf=%b, required all zero",
                     busy, done, s, cout, ovf);
            errors++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add_timing();
        bit busy_ok = 1'b1;
        bit done_early = 1'b0;
        launch(8'h05, 8'h03, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b0) done_early = 1'b1;
            step();
        end
        checks++;
        if (!busy_ok || done_early) begin
            $display("FAIL add_timing_run: busy_ok=%0d done_early=%0d, required busy in cycles 1..8 and no done",
                     busy_ok, done_early);
            errors++;
        end
        checks++;
        if ({done, busy} !== 2'b10) begin
            $display("FAIL add_timing_done9: done=%b busy=%b, required done=1 busy=0 in cycle 9", done, busy);
            errors++;
        end
        checks++;
        if ({s, cout, ovf} !== {8'h08, 1'b0, 1'b0}) begin
            $display("FAIL add_05_03: s=%h cout=%b ovf=%b, required s=08 cout=0 ovf=0", s, cout, ovf);
            errors++;
        end
        step();
        checks++;
        if ({done, busy, s} !== {1'b0, 1'b0, 8'h08}) begin
            $display("FAIL done_pulse_width: done=%b busy=%b s=%h, required done=0 busy=0 s held 08",
                     done, busy, s);
            errors++;
        end
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    task automatic test_boundaries();
        vec_t tbl [4];
        int   n;
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        foreach (tbl[i]) begin
            launch(tbl[i].va, tbl[i].vb, tbl[i].vsub);
            wait_done(n);
            checks++;
            if (n !== 9 || {s, cout, ovf} !== {tbl[i].es, tbl[i].ec, tbl[i].eo}) begin
                $display("FAIL boundary_%0d: a=%h b=%h sub=%b -> cyc=%0d s=%h cout=%b ovf=%b, required cyc=9 s=%h cout=%b ovf=%b",
                         i, tbl[i].va, tbl[i].vb, tbl[i].vsub, n, s, cout, ovf,
                         tbl[i].es, tbl[i].ec, tbl[i].eo);
                errors++;
            end
            step();
        end
    endtask

    task automatic test_start_in_run();
        int n;
        launch(8'h05, 8'h03, 1'b0);
        step();
        step();
        // Now in RUN cycle 3: try to start a different operation.
        launch(8'hFF, 8'hFF, 1'b1);
        n = 4;
        for (int c = 4; c <= 20 && done !== 1'b1; c++) begin
            step();
            n = c + 1;
        end
        checks++;
        if (n !== 9 || {s, cout, ovf} !== {8'h08, 1'b0, 1'b0}) begin
            $display("FAIL start_in_run: cyc=%0d s=%h cout=%b ovf=%b, required cyc=9 s=08 cout=0 ovf=0",
                     n, s, cout, ovf);
            errors++;
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(n);
        checks++;
        if (n !== 9 || {s, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
            $display("FAIL b2b_first: cyc=%0d s=%h cout=%b ovf=%b, required cyc=9 s=80 cout=0 ovf=1",
                     n, s, cout, ovf);
            errors++;
        end
        launch(8'h10, 8'h20, 1'b1);
        checks++;
        if ({busy, done} !== 2'b10) begin
            $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0 right after DONE", busy, done);
            errors++;
        end
        wait_done(n);
        checks++;
        if (n !== 9 || {s, cout, ovf} !== {8'hF0, 1'b0, 1'b0}) begin
            $display("FAIL b2b_second: cyc=%0d s=%h cout=%b ovf=%b, required cyc=9 s=F0 cout=0 ovf=0",
                     n, s, cout, ovf);
            errors++;
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        bit saw_done = 1'b0;
        launch(8'h7F, 8'h01, 1'b0);
        step();
        step();
        step();
        // RUN cycle 4.
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done, s, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset_mid_run: busy=%b done=%b s=%h cout=%b ovf=%b, required all zero",
                     busy, done, s, cout, ovf);
            errors++;
        end
        for (int c = 0; c < 12; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done) begin
            $display("FAIL reset_no_done: activity seen after abort=1, required 0");
            errors++;
        end
    endtask

    task automatic test_sweep();
        int           vals[$];
        int           n;
        logic [W-1:0] bb;
        logic [W:0]   sum;
        logic         eo;
        for (int v = 0; v <= 255; v += 15) vals.push_back(v);
        vals.push_back(1);
        vals.push_back(8'h7F);
        vals.push_back(8'h80);
        vals.push_back(8'hFE);
        foreach (vals[i]) begin
            foreach (vals[j]) begin
                for (int m = 0; m < 2; m++) begin
                    bb  = (m == 1) ? ~W'(vals[j]) : W'(vals[j]);
                    sum = {1'b0, W'(vals[i])} + {1'b0, bb} + (W+1)'(m);
                    eo  = (vals[i][W-1] == bb[W-1]) && (sum[W-1] != vals[i][W-1]);
                    launch(W'(vals[i]), W'(vals[j]), m[0]);
                    wait_done(n);
                    checks++;
                    if (n !== 9 || {s, cout, ovf} !== {sum[W-1:0], sum[W], eo}) begin
                        $display("FAIL sweep: a=%h b=%h sub=%0d cyc=%0d s=%h cout=%b ovf=%b, required cyc=9 s=%h cout=%b ovf=%b",
                                 W'(vals[i]), W'(vals[j]), m, n, s, cout, ovf, sum[W-1:0], sum[W], eo);
                        errors++;
                    end
                end
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add_timing();
        test_boundaries();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
